// File: rtl/ultra_sonic_pkg.sv
// rtl/ultra_sonic_pkg.sv - shared state type and timing constants for the ultrasonic ranging blocks
package ultra_sonic_pkg;

    // Responder state machine states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } us_state_t;

    // Default timing at a 50 MHz system clock
    localparam int DEF_TRIG_MIN_CYCLES = 500;      // 10 us qualified trigger
    localparam int DEF_BURST_CYCLES    = 10000;    // 200 us burst before echo
    localparam int DEF_HOLDOFF_CYCLES  = 3000000;  // 60 ms between measurements
    localparam int DEF_MAX_ECHO_CYCLES = 1900000;  // 38 ms "no object" echo

    // Echo round-trip cycles per centimetre of distance, shared with the controller
    localparam int CYCLES_PER_CM = 2900;

    // Clamp a timing constant to what a counter of the build width can reach
    function automatic int sat_limit(input int value, input int limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/ultra_sonic_sync_edge.sv
// rtl/ultra_sonic_sync_edge.sv - two-flop synchronizer with rise/fall edge pulses
module ultra_sonic_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two flops resolve metastability, the third remembers the previous level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;
    assign fall  = ~sync & sync_d;

endmodule

// File: rtl/ultra_sonic_echo_gen.sv
// rtl/ultra_sonic_echo_gen.sv - HC-SR04-style echo responder for ranging loopback and bring-up
module ultra_sonic_echo_gen
    import ultra_sonic_pkg::*;
#(
    parameter int COUNT_WIDTH     = 23,
    parameter int DELAY_WIDTH     = 16,
    parameter int TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
    parameter int BURST_CYCLES    = DEF_BURST_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int MAX_ECHO_CYCLES = DEF_MAX_ECHO_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_all,
    input  logic                   trigger_in,
    input  logic [COUNT_WIDTH-1:0] echo_width_in,
    input  logic                   echo_width_load,
    output logic                   echo_out,
    output logic                   busy_out,
    output logic                   echo_done_out,
    output logic                   short_trig_out
);

    // Delay counters are DELAY_WIDTH bits; longer requested delays saturate at the counter range
    localparam int DELAY_MAX = (1 << DELAY_WIDTH) - 1;

    localparam logic [DELAY_WIDTH-1:0] TRIG_MIN =
        DELAY_WIDTH'(sat_limit(TRIG_MIN_CYCLES, DELAY_MAX));
    localparam logic [DELAY_WIDTH-1:0] BURST_LAST =
        DELAY_WIDTH'(sat_limit(BURST_CYCLES, DELAY_MAX) - 1);
    localparam logic [DELAY_WIDTH-1:0] HOLDOFF_LAST =
        DELAY_WIDTH'(sat_limit(HOLDOFF_CYCLES, DELAY_MAX) - 1);
    localparam logic [COUNT_WIDTH-1:0] MAX_ECHO = COUNT_WIDTH'(MAX_ECHO_CYCLES);

    us_state_t              state;
    logic [DELAY_WIDTH-1:0] trig_cnt;
    logic [DELAY_WIDTH-1:0] burst_cnt;
    logic [DELAY_WIDTH-1:0] holdoff_cnt;
    logic [COUNT_WIDTH-1:0] echo_cnt;
    logic [COUNT_WIDTH-1:0] width_reg;

    logic trig_s;
    logic trig_rise;
    logic trig_fall;

    ultra_sonic_sync_edge u_trig_sync (
        .clk   (clk),
        .rst_n (reset_all),
        .din   (trigger_in),
        .level (trig_s),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    // Host-programmed echo width, clamped to the "no object" limit; usable in any state
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            width_reg <= '0;
        end else if (echo_width_load) begin
            width_reg <= (echo_width_in > MAX_ECHO) ? MAX_ECHO : echo_width_in;
        end
    end

    // Trigger qualification, burst delay, echo pulse and holdoff sequencing
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state          <= IDLE;
            trig_cnt       <= '0;
            burst_cnt      <= '0;
            holdoff_cnt    <= '0;
            echo_cnt       <= '0;
            echo_out       <= 1'b0;
            busy_out       <= 1'b0;
            echo_done_out  <= 1'b0;
            short_trig_out <= 1'b0;
        end else begin
            echo_done_out  <= 1'b0;
            short_trig_out <= 1'b0;

            case (state)
                IDLE: begin
                    // Only a fresh rise starts a measurement; a level left high from before is ignored
                    if (trig_rise) begin
                        state    <= TRIG;
                        trig_cnt <= '0;
                        busy_out <= 1'b1;
                    end
                end

                TRIG: begin
                    if (trig_fall) begin
                        if (trig_cnt >= TRIG_MIN) begin
                            state     <= BURST;
                            burst_cnt <= '0;
                        end else begin
                            state          <= IDLE;
                            busy_out       <= 1'b0;
                            short_trig_out <= 1'b1;
                        end
                    end else if (trig_s && (trig_cnt != '1)) begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end

                BURST: begin
                    if (burst_cnt == BURST_LAST) begin
                        // Snapshot the width here so later loads only affect the next measurement
                        if (width_reg == '0) begin
                            state         <= HOLDOFF;
                            holdoff_cnt   <= '0;
                            echo_done_out <= 1'b1;
                        end else begin
                            state    <= ECHO;
                            echo_cnt <= width_reg;
                            echo_out <= 1'b1;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end

                ECHO: begin
                    // echo_cnt holds the cycles of echo still owed including the current one
                    if (echo_cnt < COUNT_WIDTH'(2)) begin
                        state         <= HOLDOFF;
                        holdoff_cnt   <= '0;
                        echo_out      <= 1'b0;
                        echo_done_out <= 1'b1;
                    end else begin
                        echo_cnt <= echo_cnt - 1'b1;
                    end
                end

                HOLDOFF: begin
                    if (holdoff_cnt == HOLDOFF_LAST) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        holdoff_cnt <= holdoff_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    echo_out <= 1'b0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
